cpu_bmu_core: RTL and testbench

Bit-manipulation unit (RISC-V Zbb subset) for the integer execute stage. It takes two XLEN operands and a 6-bit operation code, computes the selected bit-manipulation function, and registers the result. The output is valid one clock after the inputs are presented. It sits beside the ALU, and the decode stage drives its control code from the BMU_* encodings.

---
 rtl/cpu_bmu_core.sv | 130 +++++++++++++
 tb/tb_cpu_bmu_core.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_bmu_core.sv
// Zbb-subset bit-manipulation unit for the integer execute stage.
// Purely combinational function select feeding a single result register (1-cycle latency).
module cpu_bmu_core #(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [XLEN-1:0] operand_a,
    input  logic        [XLEN-1:0] operand_b,
    input  logic        [5:0]      control,
    output logic        [XLEN-1:0] result
);

    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = SHW + 1;
    localparam int NB   = XLEN / 8;

    localparam logic [5:0] BMU_ANDN  = 6'd0;
    localparam logic [5:0] BMU_ORN   = 6'd1;
    localparam logic [5:0] BMU_XNOR  = 6'd2;
    localparam logic [5:0] BMU_CLZ   = 6'd3;
    localparam logic [5:0] BMU_CTZ   = 6'd4;
    localparam logic [5:0] BMU_CPOP  = 6'd5;
    localparam logic [5:0] BMU_MAX   = 6'd6;
    localparam logic [5:0] BMU_MAXU  = 6'd7;
    localparam logic [5:0] BMU_MIN   = 6'd8;
    localparam logic [5:0] BMU_MINU  = 6'd9;
    localparam logic [5:0] BMU_SEXTB = 6'd10;
    localparam logic [5:0] BMU_SEXTH = 6'd11;
    localparam logic [5:0] BMU_ZEXTH = 6'd12;
    localparam logic [5:0] BMU_ROL   = 6'd13;
    localparam logic [5:0] BMU_ROR   = 6'd14;
    localparam logic [5:0] BMU_ORCB  = 6'd15;
    localparam logic [5:0] BMU_REV8  = 6'd16;

    // Leading-zero count: stop counting at the first set bit from the MSB.
    function automatic logic [CNTW-1:0] f_clz(input logic [XLEN-1:0] v);
        logic [CNTW-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (v[i]) found = 1'b1;
            else if (!found) n = n + 1'b1;
        end
        return n;
    endfunction

    function automatic logic [CNTW-1:0] f_ctz(input logic [XLEN-1:0] v);
        logic [CNTW-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (v[i]) found = 1'b1;
            else if (!found) n = n + 1'b1;
        end
        return n;
    endfunction

    function automatic logic [CNTW-1:0] f_cpop(input logic [XLEN-1:0] v);
        logic [CNTW-1:0] n;
        n = '0;
        for (int i = 0; i < XLEN; i++) n = n + {{(CNTW-1){1'b0}}, v[i]};
        return n;
    endfunction

    logic        [XLEN-1:0]   a_u;
    logic signed [XLEN-1:0]   b_s;
    logic        [SHW-1:0]    sh_amt;
    logic        [2*XLEN-1:0] rot_l;
    logic        [2*XLEN-1:0] rot_r;
    logic                     a_lt_b_s;
    logic                     a_lt_b_u;
    logic        [XLEN-1:0]   orcb_v;
    logic        [XLEN-1:0]   rev8_v;
    logic        [XLEN-1:0]   result_d;
    logic        [XLEN-1:0]   result_q;

    assign a_u      = operand_a;
    assign b_s      = operand_b;
    assign sh_amt   = operand_b[SHW-1:0];
    assign a_lt_b_s = operand_a < b_s;
    assign a_lt_b_u = a_u < operand_b;
    // Rotates via a doubled operand so a zero amount needs no special case.
    assign rot_l    = {a_u, a_u} << sh_amt;
    assign rot_r    = {a_u, a_u} >> sh_amt;

    always_comb begin
        orcb_v = '0;
        rev8_v = '0;
        for (int i = 0; i < NB; i++) begin
            orcb_v[i*8 +: 8] = (|a_u[i*8 +: 8]) ? 8'hFF : 8'h00;
            rev8_v[i*8 +: 8] = a_u[(NB-1-i)*8 +: 8];
        end
    end

    always_comb begin
        result_d = '0;
        case (control)
            BMU_ANDN:  result_d = a_u & ~operand_b;
            BMU_ORN:   result_d = a_u | ~operand_b;
            BMU_XNOR:  result_d = ~(a_u ^ operand_b);
            BMU_CLZ:   result_d = {{(XLEN-CNTW){1'b0}}, f_clz(a_u)};
            BMU_CTZ:   result_d = {{(XLEN-CNTW){1'b0}}, f_ctz(a_u)};
            BMU_CPOP:  result_d = {{(XLEN-CNTW){1'b0}}, f_cpop(a_u)};
            BMU_MAX:   result_d = a_lt_b_s ? operand_b : a_u;
            BMU_MAXU:  result_d = a_lt_b_u ? operand_b : a_u;
            BMU_MIN:   result_d = a_lt_b_s ? a_u : operand_b;
            BMU_MINU:  result_d = a_lt_b_u ? a_u : operand_b;
            BMU_SEXTB: result_d = {{(XLEN-8){a_u[7]}}, a_u[7:0]};
            BMU_SEXTH: result_d = {{(XLEN-16){a_u[15]}}, a_u[15:0]};
            BMU_ZEXTH: result_d = {{(XLEN-16){1'b0}}, a_u[15:0]};
            BMU_ROL:   result_d = rot_l[2*XLEN-1:XLEN];
            BMU_ROR:   result_d = rot_r[XLEN-1:0];
            BMU_ORCB:  result_d = orcb_v;
            BMU_REV8:  result_d = rev8_v;
            default:   result_d = '0;
        endcase
    end

    // Result register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result_q <= '0;
        else        result_q <= result_d;
    end

    assign result = result_q;

endmodule

// File: tb/tb_cpu_bmu_core.sv
// Self-checking bench for cpu_bmu_core at XLEN=32 using an expected-value queue.
module tb_cpu_bmu_core;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] operand_a = '0;
    logic [XLEN-1:0] operand_b = '0;
    logic [5:0]      control = '0;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] exp_q[$];
    string           name_q[$];

    cpu_bmu_core #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .operand_a(operand_a),
        .operand_b(operand_b), .control(control), .result(result)
    );

    always #5 clk = ~clk;

    // Independent reference model
    function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int n;
        int sh;
        r  = '0;
        sh = int'(b[4:0]);
        case (op)
            6'd0: r = a & ~b;
            6'd1: r = a | ~b;
            6'd2: r = ~(a ^ b);
            6'd3: begin n = 0; while (n < 32 && a[31-n] == 1'b0) n++; r = 32'(n); end
            6'd4: begin n = 0; while (n < 32 && a[n] == 1'b0) n++; r = 32'(n); end
            6'd5: r = 32'($countones(a));
            6'd6: r = ($signed(a) > $signed(b)) ? a : b;
            6'd7: r = (a > b) ? a : b;
            6'd8: r = ($signed(a) < $signed(b)) ? a : b;
            6'd9: r = (a < b) ? a : b;
            6'd10: r = 32'($signed(a[7:0]));
            6'd11: r = 32'($signed(a[15:0]));
            6'd12: r = {16'h0000, a[15:0]};
            6'd13: for (int i = 0; i < 32; i++) r[(i + sh) % 32] = a[i];
            6'd14: for (int i = 0; i < 32; i++) r[i] = a[(i + sh) % 32];
            6'd15: for (int i = 0; i < 4; i++) r[i*8 +: 8] = (a[i*8 +: 8] != 8'h00) ? 8'hFF : 8'h00;
            6'd16: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input string nm);
        @(negedge clk);
        control   = op;
        operand_a = a;
        operand_b = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst_n = 1'b0;
        drive(6'd0, 32'hFF00FF00, 32'h00FF00FF, 32'hFF00FF00, "andn_latency");
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++; $display("FAIL reset_hold: got %h want %h", result, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++; $display("FAIL pre_edge: got %h want %h", result, 32'h0);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (result !== e) begin
            n_fail++; $display("FAIL %s: got %h want %h", name_q.pop_front(), result, e);
        end else void'(name_q.pop_front());
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got %h want %h", result, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_table(input logic [5:0] ops[], input logic [31:0] as[],
                             input logic [31:0] bs[], input logic [31:0] es[], input string nms[]);
        logic [31:0] e;
        string nm;
        for (int i = 0; i < ops.size(); i++) begin
            drive(ops[i], as[i], bs[i], es[i], nms[i]);
            @(posedge clk);
            #1;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (result !== e) begin
                n_fail++; $display("FAIL %s: got %h want %h", nm, result, e);
            end
        end
    endtask

    task automatic test_counts();
        run_table('{6'd3, 6'd4, 6'd5, 6'd3, 6'd4, 6'd5},
                  '{32'h6, 32'h0F000020, 32'hF0F0F0F0, 32'h0, 32'h0, 32'hFFFFFFFF},
                  '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                  '{32'd29, 32'd5, 32'd16, 32'd32, 32'd32, 32'd32},
                  '{"clz_6", "ctz", "cpop", "clz_zero", "ctz_zero", "cpop_ones"});
    endtask

    task automatic test_logic();
        run_table('{6'd0, 6'd1, 6'd2, 6'd2},
                  '{32'h12345678, 32'hFF00FF00, 32'hA5A5A5A5, 32'hF0F0F0F0},
                  '{32'h0000FFFF, 32'h00FF00FF, 32'hA5A5A5A5, 32'h0F0F0F0F},
                  '{32'h12340000, 32'hFF00FF00, 32'hFFFFFFFF, 32'h00000000},
                  '{"andn", "orn", "xnor_eq", "xnor_inv"});
    endtask

    task automatic test_rotate();
        run_table('{6'd13, 6'd14, 6'd14, 6'd13, 6'd14},
                  '{32'h80000000, 32'h1, 32'h1, 32'h12345678, 32'h12345678},
                  '{32'd1, 32'd1, 32'd33, 32'd0, 32'd8},
                  '{32'h1, 32'h80000000, 32'h80000000, 32'h12345678, 32'h78123456},
                  '{"rol_msb", "ror_1", "ror_33", "rol_0", "ror_8"});
    endtask

    task automatic test_minmax_ext();
        run_table('{6'd8, 6'd9, 6'd6, 6'd7, 6'd10, 6'd11, 6'd12},
                  '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80, 32'h8000, 32'hFFFFFFFF},
                  '{32'h1, 32'h1, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0},
                  '{32'hFFFFFFFF, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFF80, 32'hFFFF8000, 32'h0000FFFF},
                  '{"min", "minu", "max", "maxu", "sextb", "sexth", "zexth"});
    endtask

    task automatic test_byte_illegal();
        run_table('{6'd15, 6'd16, 6'd63, 6'd17},
                  '{32'h00120000, 32'h11223344, 32'hFFFFFFFF, 32'hFFFFFFFF},
                  '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h1},
                  '{32'h00FF0000, 32'h44332211, 32'h0, 32'h0},
                  '{"orcb", "rev8", "illegal_63", "illegal_17"});
    endtask

    task automatic test_back_to_back();
        logic [5:0]  op;
        logic [31:0] a, b, e;
        string nm;
        for (int i = 0; i < 200; i++) begin
            op = 6'($urandom_range(0, 18));
            a  = $urandom;
            b  = $urandom;
            if (i % 7 == 0) a = a >> (i % 32);
            drive(op, a, b, model(op, a, b), $sformatf("rand_op%0d", op));
            @(posedge clk);
            #1;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (result !== e) begin
                n_fail++; $display("FAIL %s: a=%h b=%h got %h want %h", nm, a, b, result, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_counts();
        test_logic();
        test_rotate();
        test_minmax_ext();
        test_byte_illegal();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
